// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Turns decoded NES button codes and an internal gravity timer into single game
// commands and hands them to the grid controller one at a time over a
// valid/ready handshake. It holds one pending user event and one pending
// gravity event. User input always wins over gravity. It also raises a
// one-cycle start request when START is pressed while no game is running.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; clears all state
//   btn_code     button code (0 none, 1 A, 2 B, 3 SELECT, 4 START, 5 UP,
//                6 DOWN, 7 LEFT, 8 RIGHT); held between frames
//   game_active  high while a game is running
//   level        current level, 0..15 (shortens the gravity period)
//   lock_event   one-cycle pulse when a piece lands; restarts gravity
//   cmd_ready    grid controller accepts cmd this cycle
//   cmd_valid    command offered
//   cmd          1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 SOFT_DROP,
//                6 HARD_DROP, 7 GRAVITY; 0 when idle
//   start_pulse  one-cycle new-game request
//   overrun_cnt  saturating count of user events overwritten before issue
// -----------------------------------------------------------------------------
module move_scheduler #(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int LEVEL_STEP    = 1500000,
  parameter int MIN_TICKS     = 2500000,
  parameter int CNT_W         = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn_code,
  input  logic             game_active,
  input  logic [3:0]       level,
  input  logic             lock_event,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  output logic             start_pulse,
  output logic [7:0]       overrun_cnt
);

  // Period arithmetic is done 4 bits wider than the counter so that
  // level*LEVEL_STEP can never wrap for any 4-bit level.
  localparam int PW = CNT_W + 4;

  localparam logic [PW-1:0] GRAV_P = PW'(GRAVITY_TICKS);
  localparam logic [PW-1:0] STEP_P = PW'(LEVEL_STEP);
  localparam logic [PW-1:0] MIN_P  = PW'(MIN_TICKS);

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_ROT_CW  = 3'd3;
  localparam logic [2:0] CMD_ROT_CCW = 3'd4;
  localparam logic [2:0] CMD_SOFT    = 3'd5;
  localparam logic [2:0] CMD_HARD    = 3'd6;
  localparam logic [2:0] CMD_GRAVITY = 3'd7;

  localparam logic [3:0] BTN_START = 4'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [3:0]       prev_code;
  logic             user_pend;
  logic [2:0]       user_cmd;
  logic             grav_pend;
  logic [CNT_W-1:0] grav_cnt;

  // ---------------------------------------------------------------------------
  // Button edge detection and command mapping
  // ---------------------------------------------------------------------------
  logic       btn_edge;
  logic       ev_mapped;
  logic [2:0] ev_cmd;
  logic       user_ev;
  logic       start_ev;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ev_mapped = 1'b0;
    ev_cmd    = CMD_NONE;
    case (btn_code)
      4'd1: begin ev_mapped = 1'b1; ev_cmd = CMD_ROT_CW;  end
      4'd2: begin ev_mapped = 1'b1; ev_cmd = CMD_ROT_CCW; end
      4'd5: begin ev_mapped = 1'b1; ev_cmd = CMD_HARD;    end
      4'd6: begin ev_mapped = 1'b1; ev_cmd = CMD_SOFT;    end
      4'd7: begin ev_mapped = 1'b1; ev_cmd = CMD_LEFT;    end
      4'd8: begin ev_mapped = 1'b1; ev_cmd = CMD_RIGHT;   end
      default: ;
    endcase
  end

  assign btn_edge = (btn_code != prev_code) && (btn_code != 4'd0);
  assign user_ev  = btn_edge && ev_mapped && game_active;
  assign start_ev = btn_edge && (btn_code == BTN_START) && !game_active;

  // ---------------------------------------------------------------------------
  // Gravity period: max(GRAVITY_TICKS - level*LEVEL_STEP, MIN_TICKS)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] level_sub;
  logic [PW-1:0] period;
  logic          grav_tick;

  always_comb begin
    level_sub = PW'(level) * STEP_P;
    period    = MIN_P;
    if (level_sub < GRAV_P && (GRAV_P - level_sub) > MIN_P)
      period = GRAV_P - level_sub;
  end

  // ">=" rather than "==" so a level increase that shrinks the period below
  // the current count still fires on the next cycle instead of wrapping.
  assign grav_tick = {4'd0, grav_cnt} >= (period - PW'(1));

  // FSM pulls from the slots only in IDLE. User has fixed priority.
  logic user_take;
  logic grav_take;

  assign user_take = (state == ST_IDLE) && game_active && user_pend;
  assign grav_take = (state == ST_IDLE) && game_active && !user_pend && grav_pend;

  // ---------------------------------------------------------------------------
  // Previous code and start pulse
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_code   <= 4'd0;
      start_pulse <= 1'b0;
    end else begin
      prev_code   <= btn_code;
      start_pulse <= start_ev;
    end
  end

  // ---------------------------------------------------------------------------
  // User slot (one deep) and overrun counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      user_pend   <= 1'b0;
      user_cmd    <= CMD_NONE;
      overrun_cnt <= 8'd0;
    end else if (!game_active) begin
      user_pend <= 1'b0;
    end else if (user_ev) begin
      user_pend <= 1'b1;
      user_cmd  <= ev_cmd;
      // Overwriting an event the FSM is not taking this cycle loses it.
      if (user_pend && !user_take && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end else if (user_take) begin
      user_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Gravity counter and pending flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || !game_active) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else if (lock_event) begin
      // A landed piece restarts the fall timer and drops any queued tick.
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else if (grav_tick) begin
      // A tick while already pending merges into the existing flag.
      grav_cnt  <= '0;
      grav_pend <= 1'b1;
    end else begin
      grav_cnt <= grav_cnt + 1'b1;
      if (grav_take)
        grav_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: IDLE -> ISSUE (hold until accepted) -> GAP -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (user_take) begin
            state     <= ST_ISSUE;
            cmd_valid <= 1'b1;
            cmd       <= user_cmd;
          end else if (grav_take) begin
            state     <= ST_ISSUE;
            cmd_valid <= 1'b1;
            cmd       <= CMD_GRAVITY;
          end
        end
        ST_ISSUE: begin
          // Held even if game_active drops: valid never retracts unaccepted.
          if (cmd_ready) begin
            state     <= ST_GAP;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_valid <= 1'b0;
          cmd       <= CMD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//
// Directed bench for move_scheduler with shortened gravity parameters:
// GRAVITY_TICKS=40, LEVEL_STEP=3, MIN_TICKS=12, CNT_W=8.
//   level 0  -> period 40
//   level 15 -> 40-45 would go negative, clamps to 12
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] btn_code;
  logic       game_active;
  logic [3:0] level;
  logic       lock_event;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       start_pulse;
  logic [7:0] overrun_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int t0;
  int t_first;

  move_scheduler #(
    .GRAVITY_TICKS(40),
    .LEVEL_STEP   (3),
    .MIN_TICKS    (12),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_code   (btn_code),
    .game_active(game_active),
    .level      (level),
    .lock_event (lock_event),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .start_pulse(start_pulse),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Step until cmd_valid is seen or the budget runs out.
  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, cmd_valid, 1);
  endtask

  initial begin
    reset       = 1'b1;
    btn_code    = 4'd0;
    game_active = 1'b0;
    level       = 4'd0;
    lock_event  = 1'b0;
    cmd_ready   = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_valid",   cmd_valid,   0);
    check("rst_cmd",     cmd,         0);
    check("rst_start",   start_pulse, 0);
    check("rst_overrun", overrun_cnt, 0);

    // Gravity at level 0: counter is k after k edges, reaches 39 at edge 39,
    // flag sets at edge 40, FSM offers GRAVITY at edge 41.
    reset       = 1'b0;
    game_active = 1'b1;
    t0 = cyc;
    wait_valid("grav1_seen", 100);
    check("grav1_latency", cyc - t0, 41);
    check("grav1_cmd", cmd, 7);
    t_first = cyc;
    cmd_ready = 1'b1;
    step();
    check("grav1_gap_valid", cmd_valid, 0);
    check("grav1_gap_cmd",   cmd,       0);
    wait_valid("grav2_seen", 100);
    check("grav2_spacing", cyc - t_first, 40);
    check("grav2_cmd", cmd, 7);
    step();

    // Level 15: period clamps to 12, flag at edge 12, offer at edge 13.
    level       = 4'd15;
    game_active = 1'b0;
    step();
    game_active = 1'b1;
    t0 = cyc;
    wait_valid("lvl15_seen", 100);
    check("lvl15_latency", cyc - t0, 13);
    lock_event = 1'b1;        // keep gravity quiet during the user tests
    step();
    step();
    step();
    cmd_ready = 1'b0;

    // User LEFT: slot loads at N+1, valid at N+2.
    btn_code = 4'd7;
    step();
    check("left_n1_valid", cmd_valid, 0);
    step();
    check("left_n2_valid", cmd_valid, 1);
    check("left_n2_cmd",   cmd,       1);
    repeat (10) step();
    check("left_hold_valid", cmd_valid, 1);
    check("left_hold_cmd",   cmd,       1);
    cmd_ready = 1'b1;
    step();
    check("left_gap_valid", cmd_valid, 0);
    check("left_gap_cmd",   cmd,       0);
    cmd_ready = 1'b0;
    btn_code  = 4'd0;
    step();

    // RIGHT issued, ROT_CW waits in the slot, then HARD_DROP overwrites it.
    btn_code = 4'd8; step();
    btn_code = 4'd0; step();
    btn_code = 4'd1; step();
    step();
    check("right_cmd",    cmd,         2);
    check("right_valid",  cmd_valid,   1);
    check("slot_overrun", overrun_cnt, 0);
    btn_code = 4'd0; step();
    btn_code = 4'd5; step();
    check("overwrite_overrun", overrun_cnt, 1);
    check("overwrite_cmd_held", cmd, 2);
    cmd_ready = 1'b1;
    step();                   // accept RIGHT -> GAP
    check("right_gap_valid", cmd_valid, 0);
    step();                   // IDLE
    step();                   // ISSUE with slot contents
    check("hard_cmd", cmd, 6);
    step();                   // accept HARD_DROP
    cmd_ready = 1'b0;

    // Gravity tick and DOWN edge in the same cycle. Counter is 0 after the
    // last locked edge; after 11 free edges it is 11 (= period-1).
    lock_event = 1'b0;
    repeat (11) step();
    btn_code = 4'd6;
    step();                   // tick + slot load (edge t)
    step();                   // t+1: user first
    check("simul_user_cmd", cmd, 5);
    cmd_ready = 1'b1;
    step();                   // t+2 accept
    step();                   // t+3 IDLE
    step();                   // t+4 GRAVITY offered
    check("simul_grav_cmd",   cmd,       7);
    check("simul_grav_valid", cmd_valid, 1);
    step();                   // t+5 accept

    // lock_event on the tick cycle: counter is 11 after edge t+11.
    repeat (6) step();
    lock_event = 1'b1;
    step();                   // t+12: tick suppressed, counter cleared
    lock_event = 1'b0;
    t0 = cyc;
    wait_valid("lock_restart_seen", 50);
    check("lock_restart_latency", cyc - t0, 13);
    step();                   // accept
    lock_event = 1'b1;

    // START with no game running: one-cycle pulse.
    game_active = 1'b0;
    btn_code    = 4'd0;
    step();
    btn_code = 4'd4;
    step();
    check("start_pulse_hi", start_pulse, 1);
    step();
    check("start_pulse_lo", start_pulse, 0);
    btn_code    = 4'd0;
    game_active = 1'b1;
    step();
    btn_code = 4'd4;
    step();
    check("start_ignored", start_pulse, 0);
    check("start_no_cmd",  cmd_valid,   0);

    // Reset while a command is offered: valid drops, command is lost.
    cmd_ready = 1'b0;
    btn_code  = 4'd7;
    step();
    step();
    check("pre_reset_valid", cmd_valid, 1);
    reset    = 1'b1;
    btn_code = 4'd0;
    step();
    check("reset_valid",   cmd_valid,   0);
    check("reset_cmd",     cmd,         0);
    check("reset_overrun", overrun_cnt, 0);
    reset = 1'b0;
    repeat (4) step();
    check("post_reset_valid", cmd_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between the NES input controller and the grid controller.
- Turns decoded button codes and an internal gravity timer into single game commands, and serialises them to the grid controller over a valid/ready handshake.
- Arbitrates between user input and gravity, holds at most one pending event per source, and generates the start pulse.

Parameters:
- GRAVITY_TICKS, 25000000, base gravity period in clk cycles (0.5 s at 50 MHz).
- LEVEL_STEP, 1500000, cycles removed from the period per level.
- MIN_TICKS, 2500000, floor on the gravity period.
- CNT_W, 25, gravity counter width; must hold GRAVITY_TICKS-1.

Ports:
- clk  input  1  50 MHz system clock
- reset  input  1  synchronous, active-high
- btn_code  input  4  button code from input controller: 0 none, 1 A, 2 B, 3 SELECT, 4 START, 5 UP, 6 DOWN, 7 LEFT, 8 RIGHT; held between frames
- game_active  input  1  high while a game is running
- level  input  4  current level, 0..15
- lock_event  input  1  one-cycle pulse when the grid controller lands a piece
- cmd_ready  input  1  grid controller accepts cmd this cycle
- cmd_valid  output  1  command offered
- cmd  output  3  1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 SOFT_DROP, 6 HARD_DROP, 7 GRAVITY; 0 when idle
- start_pulse  output  1  one-cycle pulse requesting a new game
- overrun_cnt  output  8  saturating count of user events overwritten before issue

Behaviour:
- Reset (synchronous, active-high, clock clk) clears all state:
  - cmd_valid=0, cmd=0, start_pulse=0, overrun_cnt=0.
  - Gravity counter=0, both pending flags=0, FSM=IDLE, previous-code register=0.
- Event detection:
  - A user event fires when btn_code != previous registered btn_code and btn_code != 0.
  - Mapping: A->ROT_CW, B->ROT_CCW, LEFT->LEFT, RIGHT->RIGHT, DOWN->SOFT_DROP, UP->HARD_DROP.
  - SELECT and codes 9..15 are ignored.
- START event:
  - With game_active=0: start_pulse=1 on the next cycle, for exactly one cycle.
  - With game_active=1: ignored.
- User slot (one deep):
  - A new event loads the slot when it is empty.
  - If the slot is full and not being accepted this cycle, the new event overwrites it and overrun_cnt increments, saturating at 255.
- Gravity period = max(GRAVITY_TICKS - level*LEVEL_STEP, MIN_TICKS), computed combinationally at CNT_W+4 bits with no wrap.
- Gravity counter:
  - Counts while game_active=1.
  - When the counter is >= period-1 (covers a level increase mid-count), it clears to 0 and sets the gravity pending flag.
  - If the flag is already set, the tick merges: the flag stays set and nothing is counted.
- lock_event clears the gravity counter and the gravity pending flag in the same cycle. lock_event wins over a simultaneous tick.
- game_active=0:
  - Gravity counter held at 0, both pending flags cleared, non-START events discarded.
  - A command already offered stays valid until accepted.
- FSM states:
  - IDLE: if the user slot is full, go to ISSUE with that command and clear the slot. Else if gravity is pending, go to ISSUE with GRAVITY and clear the flag. User input has fixed priority over gravity.
  - ISSUE: cmd_valid=1 and cmd stable until cmd_ready=1. On acceptance go to GAP.
  - GAP: one cycle with cmd_valid=0 and cmd=0, then IDLE.
- Handshake:
  - Acceptance occurs on a cycle with cmd_valid=1 and cmd_ready=1.
  - cmd_valid never drops without acceptance, except on reset.
  - Minimum spacing between accepted commands is 3 cycles.
- Latency: event edge at cycle N -> slot loaded at N+1 -> cmd_valid at N+2 if the FSM was IDLE.
- Simultaneous user event and gravity tick: both are captured, and user is issued first.
- Reset mid-ISSUE: cmd_valid drops the cycle after reset is sampled. The pending command is lost.

Test Plan:
- Reset asserted, then game_active=1, level=0, btn_code=0 -> outputs 0. First GRAVITY cmd_valid appears 25000000 cycles after reset release; cmd_ready=1 -> accepted; next cmd_valid 25000000 cycles later.
- level=15 (period clamps to 2500000); btn_code 0->7 while idle -> cmd=1 valid 2 cycles later. Hold cmd_ready=0 for 10 cycles -> cmd stays 1 and valid. Release cmd_ready -> GAP cycle.
- btn_code 0->8->0->1 on successive frames with cmd_ready=0 -> RIGHT issued; ROT_CW held pending in the slot; overrun_cnt=0. A third event before acceptance -> overrun_cnt=1.
- Gravity tick and btn_code edge to 6 land on the same cycle -> SOFT_DROP (5) issued, then GRAVITY (7) after the GAP.
- lock_event on the same cycle as a gravity tick -> no GRAVITY issued; counter restarts from 0.
- game_active=0, btn_code 0->4 -> start_pulse high exactly 1 cycle. The same edge with game_active=1 -> no pulse. Reset mid-ISSUE -> cmd_valid=0 the next cycle.
